// File: rtl/hub_slot_sched.sv
`default_nettype none
// ============================================================================
// Module      : hub_slot_sched
// Description : Hub slot timing for the cog bus. Generates the one-cycle
//               ena_bus strobe every DIV clocks and a one-hot slot owner.
//               The owner rotates in fixed order, or skips to the next
//               requesting cog when SKIP_IDLE is set. Per-cog wait counters
//               feed a worst-case latency register for profiling.
// Revision    : 1.0 - initial release
// ============================================================================
module hub_slot_sched #(
    parameter int DIV       = 2,
    parameter bit SKIP_IDLE = 1'b0,
    parameter int WBITS     = 5
) (
    input  logic             clk_cog,
    input  logic             res,
    input  logic [7:0]       cog_ena,
    input  logic [7:0]       cog_req,
    input  logic             lat_clr,
    output logic             ena_bus,
    output logic [7:0]       bus_sel,
    output logic [2:0]       slot_id,
    output logic [7:0]       grant,
    output logic             sync,
    output logic [WBITS-1:0] lat_max
);

    localparam logic [3:0]       c_div_last = 4'(DIV - 1);
    localparam logic [WBITS-1:0] c_wmax     = '1;

    logic [3:0]       r_cnt;
    logic             r_ena_bus;
    logic [7:0]       r_bus_sel;
    logic [2:0]       r_slot_id;
    logic [7:0]       r_grant;
    logic             r_sync;
    logic [WBITS-1:0] r_lat_max;
    logic [WBITS-1:0] r_wcnt [8];

    logic             w_last;
    logic [7:0]       w_cand;
    logic [2:0]       w_next_id;
    logic [2:0]       w_id_nxt;
    logic [7:0]       w_sel_nxt;
    logic             w_served;
    logic [WBITS-1:0] w_served_wait;

    // The strobe is registered from the last prescaler count, so it lands
    // in the cycle where r_cnt has just wrapped back to zero.
    assign w_last = (r_cnt == c_div_last);
    assign w_cand = cog_ena & cog_req;

    generate
        if (SKIP_IDLE) begin : g_skip
            logic [2:0] w_skip_id;
            logic [2:0] w_idx;
            // Scan offsets 8 down to 1 so the smallest matching offset wins;
            // offset 8 wraps to the current owner and is therefore last resort.
            always_comb begin
                w_skip_id = r_slot_id + 3'd1;
                w_idx     = r_slot_id;
                for (int k = 8; k >= 1; k--) begin
                    w_idx = r_slot_id + 3'(k);
                    if (w_cand[w_idx]) begin
                        w_skip_id = w_idx;
                    end
                end
            end
            assign w_next_id = w_skip_id;
        end else begin : g_fixed
            assign w_next_id = r_slot_id + 3'd1;
        end
    endgenerate

    // Owner for the coming cycle; only moves on the edge that ends a strobe.
    assign w_id_nxt      = r_ena_bus ? w_next_id : r_slot_id;
    assign w_sel_nxt     = 8'd1 << w_id_nxt;
    assign w_served      = |(r_bus_sel & w_cand);
    assign w_served_wait = r_wcnt[r_slot_id];

    // Prescaler, strobe, slot owner and the strobe-qualified grant/sync.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            r_cnt     <= 4'd0;
            r_ena_bus <= 1'b0;
            r_bus_sel <= 8'b0000_0001;
            r_slot_id <= 3'd0;
            r_grant   <= 8'd0;
            r_sync    <= 1'b0;
        end else begin
            r_cnt     <= w_last ? 4'd0 : r_cnt + 4'd1;
            r_ena_bus <= w_last;
            r_bus_sel <= w_sel_nxt;
            r_slot_id <= w_id_nxt;
            r_grant   <= w_last ? (w_sel_nxt & w_cand) : 8'd0;
            r_sync    <= w_last && (w_sel_nxt == 8'b0000_0001);
        end
    end

    // Per-cog wait counters, advanced once per slot at the strobe edge.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            for (int i = 0; i < 8; i++) begin
                r_wcnt[i] <= '0;
            end
        end else if (r_ena_bus) begin
            for (int i = 0; i < 8; i++) begin
                if (!w_cand[i] || r_bus_sel[i]) begin
                    r_wcnt[i] <= '0;
                end else if (r_wcnt[i] != c_wmax) begin
                    r_wcnt[i] <= r_wcnt[i] + 1'b1;
                end
            end
        end
    end

    // Worst-case wait of a served request; a clear beats a same-edge update.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            r_lat_max <= '0;
        end else if (lat_clr) begin
            r_lat_max <= '0;
        end else if (r_ena_bus && w_served && (w_served_wait > r_lat_max)) begin
            r_lat_max <= w_served_wait;
        end
    end

    assign ena_bus = r_ena_bus;
    assign bus_sel = r_bus_sel;
    assign slot_id = r_slot_id;
    assign grant   = r_grant;
    assign sync    = r_sync;
    assign lat_max = r_lat_max;

endmodule
`default_nettype wire
